// File: rtl/des_byte_loader_if.sv
// Byte-stream handshake between a serial source and the DES loader.
// The source drives data/valid; the loader answers with ready.
interface des_byte_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/des_byte_loader.sv
// Framed byte loader assembling 64-bit DES key/text words.
// Optional stall abort: define DES_LOADER_TIMEOUT_EN.
module des_byte_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  des_byte_loader_if.slave in_if,
  output logic [63:0]      key,
  output logic             key_valid,
  output logic [63:0]      text,
  output logic             text_valid,
  output logic             decrypt,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0] HDR_K = 8'h4B;
  localparam logic [7:0] HDR_E = 8'h45;
  localparam logic [7:0] HDR_D = 8'h44;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_EMIT
  } state_t;

  typedef enum logic [1:0] {
    F_KEY,
    F_ENC,
    F_DEC
  } ftype_t;

  state_t           state_q;
  ftype_t           ftype_q;
  logic [2:0]       cnt_q;
  logic [55:0]      shadow_q;
  logic [63:0]      key_q;
  logic [63:0]      text_q;
  logic             dec_q;
  logic             kv_q;
  logic             tv_q;
  logic             loaded_q;
  logic [ERR_W-1:0] err_q;
`ifdef DES_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    timer_q;
`endif

  logic             fire;
  logic [63:0]      word;
  logic [ERR_W-1:0] err_d;

  assign in_if.in_ready = (state_q != S_EMIT);
  assign fire  = in_if.in_valid && in_if.in_ready;
  assign word  = {shadow_q, in_if.in_data};
  assign err_d = (err_q == '1) ? err_q : err_q + 1'b1;

  assign key        = key_q;
  assign key_valid  = kv_q;
  assign text       = text_q;
  assign text_valid = tv_q;
  assign decrypt    = dec_q;
  assign busy       = (state_q != S_IDLE);
  assign err_cnt    = err_q;

  // Outputs load on the edge that takes the last byte, so they are
  // visible during the EMIT cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ftype_q  <= F_KEY;
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      text_q   <= '0;
      dec_q    <= 1'b0;
      kv_q     <= 1'b0;
      tv_q     <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= '0;
`ifdef DES_LOADER_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      kv_q <= 1'b0;
      tv_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fire) begin
            cnt_q <= '0;
`ifdef DES_LOADER_TIMEOUT_EN
            timer_q <= '0;
`endif
            unique case (1'b1)
              in_if.in_data == HDR_K: begin
                ftype_q <= F_KEY;
                state_q <= S_PAYLOAD;
              end
              in_if.in_data == HDR_E: begin
                ftype_q <= F_ENC;
                state_q <= S_PAYLOAD;
              end
              in_if.in_data == HDR_D: begin
                ftype_q <= F_DEC;
                state_q <= S_PAYLOAD;
              end
              default: err_q <= err_d;
            endcase
          end
        end
        S_PAYLOAD: begin
          if (fire) begin
            shadow_q <= word[55:0];
            cnt_q    <= cnt_q + 3'd1;
`ifdef DES_LOADER_TIMEOUT_EN
            timer_q  <= '0;
`endif
            if (cnt_q == 3'd7) begin
              state_q <= S_EMIT;
              if (ftype_q == F_KEY) begin
                key_q    <= word;
                kv_q     <= 1'b1;
                loaded_q <= 1'b1;
              end else if (loaded_q) begin
                text_q <= word;
                dec_q  <= (ftype_q == F_DEC);
                tv_q   <= 1'b1;
              end else begin
                err_q <= err_d;
              end
            end
          end
`ifdef DES_LOADER_TIMEOUT_EN
          else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            err_q   <= err_d;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        S_EMIT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/des_byte_loader.md
# des_byte_loader

Byte-stream front end for the DES datapath: it parses framed commands from an 8-bit ready/valid source such as a UART receiver and assembles 64-bit key and text words. It then issues single-cycle `key_valid` / `text_valid` strobes, with `decrypt` aligned, directly into the dual-instance DES core. Malformed, premature or stalled frames are discarded and counted.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed between payload bytes before a frame is aborted.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- `key`  out  64  last loaded key; held between loads.
- `key_valid`  out  1  one-cycle strobe; `key` is new.
- `text`  out  64  last loaded block; held between loads.
- `text_valid`  out  1  one-cycle strobe; `text` is new.
- `decrypt`  out  1  mode of the current `text`; 1 = decrypt.
- `busy`  out  1  a frame is in progress (state is not IDLE).
- `err_cnt`  out  ERR_W  saturating count of discarded frames.

## Operation
- Frame format: one header byte followed by 8 payload bytes, MSB first. The first payload byte lands in bits [63:56].
- Header values:
  - 0x4B ('K'): key load.
  - 0x45 ('E'): encrypt block.
  - 0x44 ('D'): decrypt block.
- States:
  - IDLE: `in_ready`=1. On an accepted byte:
    - valid header: latch the frame type, clear the byte counter, go to PAYLOAD.
    - any other value: increment `err_cnt`, stay in IDLE.
  - PAYLOAD: `in_ready`=1. Each accepted byte shifts into a 64-bit shadow register and increments a 3-bit counter. When the 8th byte is accepted (counter==7), go to EMIT.
  - EMIT: `in_ready`=0, lasts exactly one cycle, then returns to IDLE.
    - Key frame: `key` <= shadow, `key_valid`=1, set the internal `key_loaded` flag.
    - E/D frame with `key_loaded`=1: `text` <= shadow, `decrypt` <= (type=='D'), `text_valid`=1.
    - E/D frame with `key_loaded`=0: no strobe, `text` and `decrypt` unchanged, increment `err_cnt`.
- `key`, `text` and `decrypt` change only in EMIT. The shadow register never drives the outputs directly.
- `key_valid` and `text_valid` are never high in the same cycle.
- `err_cnt` saturates at 2^ERR_W−1 and is cleared only by `rst`.
- When `rst`=1, the block returns to IDLE within the same edge: the partial frame is lost and `key_loaded` is cleared.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `key`, `text`, `decrypt`, `key_valid`, `text_valid`, `busy`, `err_cnt` all 0.
  - `key_loaded`=0.
- Latency: if the 8th payload byte is accepted at edge N, the strobe, the new data and the new `decrypt` are all visible in cycle N+1. `in_ready` is 0 in that cycle. The next header can be accepted at edge N+2.
- Minimum frame period is 10 cycles (9 bytes + EMIT).
- `in_valid` may stay high during EMIT; that byte is held by the source and not consumed.
- `busy` is high in PAYLOAD and EMIT.

## Configuration
- `DES_LOADER_TIMEOUT_EN` defined:
  - A counter in PAYLOAD resets on every accepted byte.
  - If TIMEOUT_CYCLES consecutive cycles pass with no accepted byte, the loader returns to IDLE, discards the partial frame and increments `err_cnt`.
  - If a byte is accepted on the same cycle the timeout would fire, the byte wins and the counter restarts.
- Not defined: no timer logic. PAYLOAD waits indefinitely.

## Test plan
- Reset, then stream 'K', 0x13,0x34,0x57,0x79,0x9B,0xBC,0xDF,0xF1 with back-to-back `in_valid` -> `key_valid` is a single pulse the cycle after the last byte, `key`=0x133457799BBCDFF1, `err_cnt`=0.
- After the key frame, send 'E' + 0x0123456789ABCDEF -> one `text_valid` pulse, `text`=0x0123456789ABCDEF, `decrypt`=0. Then send 'D' + 0x85E813540F0AB405 -> `text_valid` pulse with `decrypt`=1, and `key` unchanged.
- After reset, send 'E' + 8 bytes with no prior key -> no `text_valid`, `err_cnt`=1. Send header 0x00 -> `err_cnt`=2, state stays IDLE.
- Hold `in_valid`=1 continuously across two consecutive 'E' frames -> `in_ready` is 0 only in each EMIT cycle, the second frame's header is accepted at N+2, and no byte is lost or duplicated.
- With `DES_LOADER_TIMEOUT_EN` and TIMEOUT_CYCLES=16: send 'E' + 3 bytes, then idle for 16 cycles -> `busy` falls, `err_cnt` increments. A following full 'E' frame is parsed correctly. Without the macro, the same stall keeps `busy`=1.
- Force `err_cnt` to saturation with ERR_W=2 by sending 5 bad headers -> `err_cnt` stays 3. Assert `rst` mid-PAYLOAD -> all outputs return to reset values on the next edge.
